midi_stream_parser: RTL and testbench
=====================================

// Module: midi_stream_parser
// PURPOSE
//  Converts the raw MIDI byte stream from the UART receiver into complete channel-voice messages.
//  Supports running status, 1- and 2-data-byte messages, SysEx skipping, real-time byte transparency
//  and per-channel filtering. Buffers messages in a small FIFO with a valid/ready output to the voice allocator.
// PARAMETERS
//  CHANNEL_MASK  16'hFFFF  bit n=1 accepts MIDI channel n; other channels parsed but discarded
//  FIFO_DEPTH    4         output message FIFO entries, power of 2, >=2
//  VEL0_IS_OFF   1         1: note-on (0x9) with velocity 0 emitted as note-off (0x8), velocity kept 0
// PORTS
//  clock         in   1    system clock
//  reset         in   1    synchronous, active-high reset
//  rx_byte       in   8    byte from UART receiver
//  rx_valid      in   1    1-cycle strobe, rx_byte valid; no backpressure on this side
//  msg_out       out  18   MIDI::message_t {message_type[3:0], data_byte1[6:0], data_byte2[6:0]}
//  msg_channel   out  4    channel of msg_out
//  msg_valid     out  1    FIFO non-empty
//  msg_ready     in   1    consumer accepts msg_out when msg_valid & msg_ready
//  overflow      out  1    sticky: a complete message was dropped because the FIFO was full
//  overflow_clr  in   1    clears overflow (reset also clears it)
// BEHAVIOUR
//  Reset: state=IDLE, running status cleared, FIFO empty, msg_valid=0, msg_out=0, msg_channel=0, overflow=0.
//  Byte classes (only examined when rx_valid=1):
//   F8-FF real-time: ignored entirely; state, running status and partial data unchanged.
//   F0: enter SYSEX, clear running status. F1-F7 system common: clear running status, go IDLE.
//   80-EF channel status: latch type=byte[7:4], channel=byte[3:0]; go WAIT_D1 (discards any partial message).
//   00-7F data: handled per state below.
//  Data-byte count: types 8,9,A,B,E -> 2; types C,D -> 1.
//  FSM:
//   IDLE    : data bytes ignored (no running status).
//   WAIT_D1 : data -> latch d1; count=1 -> emit (d2=0), stay WAIT_D1; count=2 -> WAIT_D2.
//   WAIT_D2 : data -> emit {type,d1,byte}; go WAIT_D1 (running status retained).
//   SYSEX   : data ignored; F7 -> IDLE; any 80-EF handled as channel status; real-time ignored.
//  Emit: message computed in the byte's cycle, written to FIFO at the next clock edge; earliest msg_valid is 1 cycle
//   after the final data byte's rx_valid. Emitted only if CHANNEL_MASK[channel]=1; otherwise discarded silently, no overflow.
//  VEL0_IS_OFF=1 and type 9 with d2=0: stored type=8.
//  Type A/E messages are passed through with raw type nibble; consumers ignore unknown types.
//  FIFO: first-word-fall-through; msg_out/msg_channel show head entry (0 when empty).
//   Full and emit with no simultaneous pop -> message dropped, overflow<=1.
//   Full with simultaneous pop (msg_valid&msg_ready) and emit -> both happen, no drop.
//   Empty with emit -> msg_valid rises the next cycle; no bypass in the emit cycle.
//   overflow set and overflow_clr asserted in the same cycle -> overflow stays 1.
//   Pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide.
//  reset mid-message or mid-SysEx: all state discarded; first data byte after reset is ignored.
// STRUCTURE
//  MIDI package additions: midi_state_t enum {IDLE,WAIT_D1,WAIT_D2,SYSEX}; constants SYSEX_START=8'hF0,
//   SYSEX_END=8'hF7, REALTIME_MIN=8'hF8; function data_len(message_type_t) returning 1 or 2.
//  Sub-module: midi_msg_fifo (parametrised FWFT FIFO, payload = message_t + channel).
//  The parser FSM is implemented in this file.
// TESTING
//  90 3C 64 -> one msg {9,3C,64}, ch0; msg_valid 1 cycle after last byte.
//  91 40 7F 41 50 -> two msgs {9,40,7F},{9,41,50} ch1 via running status.
//  C2 05 06 -> two msgs {C,05,00},{C,06,00} ch2; 92 3C 00 with VEL0_IS_OFF=1 -> {8,3C,00}.
//  90 F8 3C FE 64 -> single {9,3C,64}; F0 01 02 F7 3C 64 -> no output; F2 3C 64 -> no output.
//  CHANNEL_MASK=16'h0001: 91 3C 64 -> no output, overflow stays 0; 90 3C 64 -> output.
//  msg_ready=0, FIFO_DEPTH+1 messages -> FIFO_DEPTH held, overflow=1; drain order intact; overflow_clr -> 0.

Source files
------------

// File: rtl/midi_stream_parser_pkg.sv
// Shared MIDI types, byte constants and the data-length helper used by the
// stream parser and its message FIFO.
package midi_stream_parser_pkg;

    typedef logic [3:0] message_type_t;

    typedef struct packed {
        message_type_t message_type;
        logic [6:0]    data_byte1;
        logic [6:0]    data_byte2;
    } message_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } midi_state_t;

    localparam logic [7:0] SYSEX_START  = 8'hF0;
    localparam logic [7:0] SYSEX_END    = 8'hF7;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    localparam message_type_t TYPE_NOTE_OFF = 4'h8;
    localparam message_type_t TYPE_NOTE_ON  = 4'h9;

    // Program change (C) and channel pressure (D) carry one data byte; the rest carry two.
    function automatic logic [1:0] data_len(input message_type_t t);
        return ((t == 4'hC) || (t == 4'hD)) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/midi_stream_parser_fifo.sv
// First-word-fall-through FIFO for parsed messages. The head entry is shown on
// rd_data while not empty and reads as zero when empty. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module midi_msg_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 22
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         not_empty,
    output logic         full
);
    import midi_stream_parser_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_fire;
    logic          pop_fire;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign pop_fire  = pop && not_empty;
    assign push_fire = push && (!full || pop_fire);
    assign rd_data   = not_empty ? mem_q[rd_ptr_q] : '0;

    // Next pointers, occupancy and storage; pointers wrap naturally at DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_fire) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/midi_stream_parser.sv
// MIDI byte-stream parser: tracks running status, skips SysEx, ignores
// real-time bytes, filters by channel and queues complete channel-voice
// messages into a FWFT FIFO.
// Output handshake: an entry transfers on any clock edge where
// msg_valid && msg_ready; msg_out/msg_channel stay stable while msg_valid
// is high and msg_ready is low.
module midi_stream_parser
    import midi_stream_parser_pkg::*;
#(
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
    parameter int          FIFO_DEPTH   = 4,
    parameter bit          VEL0_IS_OFF  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output message_t    msg_out,
    output logic [3:0]  msg_channel,
    output logic        msg_valid,
    input  logic        msg_ready,
    output logic        overflow,
    input  logic        overflow_clr,
    output midi_state_t state_dbg
);

    midi_state_t   state_q, state_d;
    message_type_t type_q, type_d;
    logic [3:0]    chan_q, chan_d;
    logic [6:0]    d1_q, d1_d;
    logic          overflow_q, overflow_d;
    logic          emit;
    message_t      emit_msg;
    message_t      store_msg;
    logic          push;
    logic          pop_fire;
    logic          fifo_full;

    // Byte classification and parser next-state; real-time bytes leave everything untouched.
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        chan_d   = chan_q;
        d1_d     = d1_q;
        emit     = 1'b0;
        emit_msg = '0;
        if (rx_valid && (rx_byte < REALTIME_MIN)) begin
            if (rx_byte == SYSEX_START) begin
                state_d = SYSEX;
            end else if (rx_byte[7:4] == 4'hF) begin
                // System common (including SYSEX_END) cancels running status.
                state_d = IDLE;
            end else if (rx_byte[7]) begin
                type_d  = rx_byte[7:4];
                chan_d  = rx_byte[3:0];
                state_d = WAIT_D1;
            end else begin
                case (state_q)
                    WAIT_D1: begin
                        d1_d = rx_byte[6:0];
                        if (data_len(type_q) == 2'd1) begin
                            emit     = 1'b1;
                            emit_msg = {type_q, rx_byte[6:0], 7'd0};
                        end else begin
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        emit     = 1'b1;
                        emit_msg = {type_q, d1_q, rx_byte[6:0]};
                        state_d  = WAIT_D1;
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // Note-on with zero velocity is stored as note-off when enabled.
    always_comb begin
        store_msg = emit_msg;
        if (VEL0_IS_OFF && (emit_msg.message_type == TYPE_NOTE_ON) &&
            (emit_msg.data_byte2 == 7'd0)) begin
            store_msg.message_type = TYPE_NOTE_OFF;
        end
    end

    assign push     = emit && CHANNEL_MASK[chan_q];
    assign pop_fire = msg_valid && msg_ready;

    // Sticky overflow: a drop in the same cycle as a clear wins.
    always_comb begin
        overflow_d = overflow_q;
        if (push && fifo_full && !pop_fire) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Parser state, running status and overflow registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            type_q     <= '0;
            chan_q     <= '0;
            d1_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            chan_q     <= chan_d;
            d1_q       <= d1_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign state_dbg = state_q;

    midi_msg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(message_t) + 4)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({store_msg, chan_q}),
        .pop       (msg_ready),
        .rd_data   ({msg_out, msg_channel}),
        .not_empty (msg_valid),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_midi_stream_parser.sv
// Directed bench for midi_stream_parser: default-parameter instance for the
// main behaviour and a channel-0-only instance for filtering.
module tb_midi_stream_parser;
    import midi_stream_parser_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        msg_ready;
    logic        overflow_clr;
    logic        msg_ready_m;
    logic        overflow_clr_m;

    message_t    msg_out, msg_out_m;
    logic [3:0]  msg_channel, msg_channel_m;
    logic        msg_valid, msg_valid_m;
    logic        overflow, overflow_m;
    midi_state_t state_dbg, state_dbg_m;

    midi_stream_parser dut (
        .clock        (clock),
        .reset        (reset),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .msg_out      (msg_out),
        .msg_channel  (msg_channel),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .state_dbg    (state_dbg)
    );

    midi_stream_parser #(.CHANNEL_MASK(16'h0001)) dut_m (
        .clock        (clock),
        .reset        (reset),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .msg_out      (msg_out_m),
        .msg_channel  (msg_channel_m),
        .msg_valid    (msg_valid_m),
        .msg_ready    (msg_ready_m),
        .overflow     (overflow_m),
        .overflow_clr (overflow_clr_m),
        .state_dbg    (state_dbg_m)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [21:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] mk(input logic [3:0] t, input logic [7:0] a,
                                       input logic [7:0] b, input logic [3:0] c);
        return {t, a[6:0], b[6:0], c};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a);
        send_byte(b);
        send_byte(c);
    endtask

    // Pops every expected entry in order, with a bounded wait for each.
    task automatic drain(input string tag);
        logic [21:0] e;
        logic        seen;
        while (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                if (msg_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check({tag, "_valid"}, 32'(seen), 32'd1);
            if (seen) begin
                check({tag, "_msg"}, 32'({msg_out, msg_channel}), 32'(e));
                msg_ready = 1'b1;
                @(posedge clock);
                #1 msg_ready = 1'b0;
            end
        end
        @(negedge clock);
        check({tag, "_empty"}, 32'(msg_valid), 32'd0);
    endtask

    task automatic expect_none(input string tag);
        repeat (3) @(negedge clock);
        check(tag, 32'(msg_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset          = 1'b1;
        rx_byte        = 8'h00;
        rx_valid       = 1'b0;
        msg_ready      = 1'b0;
        overflow_clr   = 1'b0;
        msg_ready_m    = 1'b0;
        overflow_clr_m = 1'b0;
        do_reset();

        // Reset state
        @(negedge clock);
        check("rst_valid", 32'(msg_valid), 32'd0);
        check("rst_msg", 32'({msg_out, msg_channel}), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        // 90 3C 64: no bypass in the emit cycle, valid one cycle later
        send_byte(8'h90);
        send_byte(8'h3C);
        rx_byte  = 8'h64;
        rx_valid = 1'b1;
        @(negedge clock);
        check("no_bypass", 32'(msg_valid), 32'd0);
        @(posedge clock);
        #1 rx_valid = 1'b0;
        @(negedge clock);
        check("lat_valid", 32'(msg_valid), 32'd1);
        exp_q.push_back(mk(4'h9, 8'h3C, 8'h64, 4'h0));
        drain("note_on");

        // Running status on channel 1
        send3(8'h91, 8'h40, 8'h7F);
        send_byte(8'h41);
        send_byte(8'h50);
        exp_q.push_back(mk(4'h9, 8'h40, 8'h7F, 4'h1));
        exp_q.push_back(mk(4'h9, 8'h41, 8'h50, 4'h1));
        drain("running");

        // One-data-byte messages, then velocity-0 note-on
        send3(8'hC2, 8'h05, 8'h06);
        send3(8'h92, 8'h3C, 8'h00);
        exp_q.push_back(mk(4'hC, 8'h05, 8'h00, 4'h2));
        exp_q.push_back(mk(4'hC, 8'h06, 8'h00, 4'h2));
        exp_q.push_back(mk(4'h8, 8'h3C, 8'h00, 4'h2));
        drain("prog_vel0");

        // Real-time bytes interleaved
        send3(8'h90, 8'hF8, 8'h3C);
        send_byte(8'hFE);
        send_byte(8'h64);
        exp_q.push_back(mk(4'h9, 8'h3C, 8'h64, 4'h0));
        drain("realtime");

        // SysEx skipped and running status cleared
        send_byte(8'hF0);
        @(negedge clock);
        check("sysex_state", 32'(state_dbg), 32'(SYSEX));
        send3(8'h01, 8'h02, 8'hF7);
        send_byte(8'h3C);
        send_byte(8'h64);
        expect_none("sysex_none");

        // System common cancels running status
        send_byte(8'h90);
        send3(8'hF2, 8'h3C, 8'h64);
        expect_none("common_none");

        // Pitch bend passthrough, channel pressure, status mid-message
        send3(8'hE3, 8'h01, 8'h40);
        send_byte(8'hD4);
        send_byte(8'h7F);
        send3(8'h90, 8'h3C, 8'h91);
        send_byte(8'h10);
        send_byte(8'h20);
        exp_q.push_back(mk(4'hE, 8'h01, 8'h40, 4'h3));
        exp_q.push_back(mk(4'hD, 8'h7F, 8'h00, 4'h4));
        exp_q.push_back(mk(4'h9, 8'h10, 8'h20, 4'h1));
        drain("mixed");

        // Reset mid-message discards everything
        send_byte(8'h90);
        send_byte(8'h3C);
        do_reset();
        send3(8'h64, 8'h55, 8'h66);
        expect_none("mid_reset");

        // Overflow: fill with msg_ready low
        do_reset();
        send_byte(8'h90);
        for (int n = 1; n <= 4; n++) begin
            send_byte(8'(n));
            send_byte(8'h40);
        end
        @(negedge clock);
        check("full_no_ovf", 32'(overflow), 32'd0);
        send_byte(8'h05);
        send_byte(8'h40);
        @(negedge clock);
        check("ovf_set", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        @(posedge clock);
        #1 overflow_clr = 1'b0;
        @(negedge clock);
        check("ovf_clr", 32'(overflow), 32'd0);
        // Drop and clear in the same cycle: set wins
        send_byte(8'h06);
        rx_byte      = 8'h40;
        rx_valid     = 1'b1;
        overflow_clr = 1'b1;
        @(posedge clock);
        #1;
        rx_valid     = 1'b0;
        overflow_clr = 1'b0;
        @(negedge clock);
        check("ovf_set_wins", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        @(posedge clock);
        #1 overflow_clr = 1'b0;
        // Full with simultaneous pop and push: no drop
        send_byte(8'h07);
        rx_byte   = 8'h40;
        rx_valid  = 1'b1;
        msg_ready = 1'b1;
        @(posedge clock);
        #1;
        rx_valid  = 1'b0;
        msg_ready = 1'b0;
        @(negedge clock);
        check("pop_push_ovf", 32'(overflow), 32'd0);
        exp_q.push_back(mk(4'h9, 8'h02, 8'h40, 4'h0));
        exp_q.push_back(mk(4'h9, 8'h03, 8'h40, 4'h0));
        exp_q.push_back(mk(4'h9, 8'h04, 8'h40, 4'h0));
        exp_q.push_back(mk(4'h9, 8'h07, 8'h40, 4'h0));
        drain("ovf_drain");

        // Channel filter on the channel-0-only instance
        do_reset();
        send3(8'h91, 8'h3C, 8'h64);
        @(negedge clock);
        check("mask_drop_valid", 32'(msg_valid_m), 32'd0);
        check("mask_drop_ovf", 32'(overflow_m), 32'd0);
        send3(8'h90, 8'h3C, 8'h64);
        @(negedge clock);
        check("mask_pass_valid", 32'(msg_valid_m), 32'd1);
        check("mask_pass_msg", 32'({msg_out_m, msg_channel_m}),
              32'(mk(4'h9, 8'h3C, 8'h64, 4'h0)));

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
